shift_arb: RTL and testbench
============================

// Module: shift_arb
// PURPOSE
//  - Shares one combinational barrel shifter (SLL/SRL/SRA) between NREQ requesters, e.g. ALU and bit-manip/CSR paths.
//  - Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle.
//  - The result is registered and returned on a single response channel, tagged with the requester ID.
// PARAMETERS
//  DW    32  data width; shift amount width SW = $clog2(DW)
//  NREQ  2   number of requesters (>=2); ID width IW = $clog2(NREQ)
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  flush       in   1        sync; discards held result, no response for it
//  req_valid   in   NREQ     per-requester request valid
//  req_ready   out  NREQ     per-requester accept (one-hot or zero)
//  req_src     in   NREQ*DW  operand, requester i at [i*DW +: DW]
//  req_n       in   NREQ*SW  shift amount, requester i at [i*SW +: SW]
//  req_op      in   NREQ*2   00 SLL, 01 SRL, 11 SRA, 10 reserved
//  resp_valid  out  1        result held in output register
//  resp_ready  in   1        consumer accepts result
//  resp_data   out  DW       shift result
//  resp_id     out  IW       index of the requester that issued it
//  resp_err    out  1        op was reserved (10); resp_data = 0
// BEHAVIOUR
//  - Reset: resp_valid=0, resp_data=0, resp_id=0, resp_err=0; RR pointer=0 (requester 0 highest priority).
//  - Reset mid-operation drops any held result silently.
//  - Output register state: EMPTY (resp_valid=0) / FULL (resp_valid=1).
//  - can_accept = !resp_valid | resp_ready. This allows back-to-back issue at 1 op/cycle under no backpressure.
//  - Arbiter: grant = first set req_valid bit searching from rr_ptr upward, with wrap.
//  - req_ready = grant & {NREQ{can_accept & !flush}}. req_ready is combinational from req_valid/resp state, never from req_src/req_n/req_op.
//  - Accept (req_valid[i] & req_ready[i]):
//    - next cycle resp_valid=1, resp_data=shift(src_i,n_i,op_i), resp_id=i, resp_err=(op_i==10).
//    - rr_ptr <= (i+1) mod NREQ.
//    - Latency is exactly 1 cycle.
//  - rr_ptr changes only on accept. With no grant it holds, so a stalled winner keeps priority.
//  - FULL & !resp_ready: resp_* hold stable, all req_ready=0.
//  - FULL & resp_ready & no new accept: resp_valid->0 next cycle. resp_data/resp_id/resp_err keep their last values.
//  - FULL & resp_ready & accept in the same cycle: the register reloads and resp_valid stays 1 (no bubble).
//  - flush=1: resp_valid->0 next cycle regardless of resp_ready. No accept happens that cycle. rr_ptr is unchanged.
//  - Arithmetic:
//    - SLL fills zeros at LSBs.
//    - SRL fills zeros at MSBs.
//    - SRA fills with src[DW-1].
//    - n=0 returns src unchanged for all valid ops.
//    - n ranges 0..DW-1; no modulo beyond SW bits.
//  - Requesters are expected to hold req_* stable while req_valid is high and not yet accepted. The block does not check this.
//  - resp_id is only meaningful when resp_valid=1.
// STRUCTURE
//  - Shared package shift_pkg:
//    - localparam op codes OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11, OP_RSV=2'b10
//    - typedef shift_op_t (2 bits)
//  - Sub-module shift_rr_arb (NREQ parameterised):
//    - inputs req, advance (accept strobe); outputs one-hot grant, grant index
//    - holds rr_ptr; async active-low reset on clk/rst_n
//  - Top level: operand mux by grant index, shift datapath (reverse/shift/reverse or direct shifts), output register.
// TESTING
//  1. Req0 SLL src=0x0000_0001 n=4 -> next cycle resp_valid=1, resp_data=0x0000_0010, resp_id=0, resp_err=0.
//  2. SRA src=0x8000_0000 n=31 -> 0xFFFF_FFFF; SRL same operands -> 0x0000_0001; n=0 any op -> src.
//  3. Both requesters valid continuously, resp_ready=1 -> grants alternate 0,1,0,1. resp_valid stays 1 every cycle after the first.
//  4. Hold resp_ready=0 for 3 cycles with both requests pending -> req_ready=0 and resp_* stable; on release, the pending winner issues with no bubble.
//  5. Reserved op 10 from req1 -> resp_err=1, resp_data=0x0, resp_id=1; the arbiter still advances.
//  6. Assert rst_n=0 while FULL; separately, assert flush with resp_ready=0 -> resp_valid=0 next cycle, no stale response, rr_ptr=0 after reset only.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// shift_pkg: shift op codes and output-register state shared by shift_arb and its bench
package shift_pkg;
  typedef logic [1:0] shift_op_t;
  localparam shift_op_t OP_SLL = 2'b00;
  localparam shift_op_t OP_SRL = 2'b01;
  localparam shift_op_t OP_SRA = 2'b11;
  localparam shift_op_t OP_RSV = 2'b10;
  typedef enum logic {EMPTY, FULL} resp_state_t;
endpackage

// File: rtl/shift_arb_if.sv
// shift_arb_if: NREQ valid/ready request channels (src, n, op) and one tagged response channel (data, id, err)
interface shift_arb_if #(parameter int DW = 32, parameter int NREQ = 2);
  localparam int SW = $clog2(DW);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*DW-1:0] req_src;
  logic [NREQ*SW-1:0] req_n;
  logic [NREQ*2-1:0] req_op;
  logic resp_valid;
  logic resp_ready;
  logic [DW-1:0] resp_data;
  logic [IW-1:0] resp_id;
  logic resp_err;
  modport master (
    output req_valid, req_src, req_n, req_op, resp_ready,
    input req_ready, resp_valid, resp_data, resp_id, resp_err
  );
  modport slave (
    input req_valid, req_src, req_n, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err
  );
endinterface

// File: rtl/shift_rr_arb.sv
// shift_rr_arb: round-robin arbiter; ports clk, rst_n, req, advance in; one-hot grant and grant_idx out; rr_ptr moves past the winner only on advance
module shift_rr_arb #(parameter int NREQ = 2) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NREQ-1:0] req,
  input  logic advance,
  output logic [NREQ-1:0] grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] rr_ptr;
  logic found;
  always_comb begin
    grant = '0;
    grant_idx = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        grant[(int'(rr_ptr) + k) % NREQ] = 1'b1;
        grant_idx = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (advance) rr_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/shift_arb.sv
// shift_arb: round-robin shared SLL/SRL/SRA barrel shifter with a registered tagged response; ports clk, rst_n, flush plus shift_arb_if.slave bus
module shift_arb import shift_pkg::*; #(parameter int DW = 32, parameter int NREQ = 2) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  shift_arb_if.slave bus
);
  localparam int SW = $clog2(DW);
  localparam int IW = $clog2(NREQ);
  resp_state_t state_q, state_d;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] gidx;
  logic can_accept, advance;
  logic [DW-1:0] src, sra, result;
  logic [SW-1:0] n;
  shift_op_t op;
  assign can_accept = state_q == EMPTY || bus.resp_ready;
  assign bus.req_ready = grant & {NREQ{can_accept & !flush}};
  assign advance = |bus.req_ready;
  assign bus.resp_valid = state_q == FULL;
  shift_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(bus.req_valid),
    .advance(advance),
    .grant(grant),
    .grant_idx(gidx)
  );
  assign src = bus.req_src[gidx*DW +: DW];
  assign n = bus.req_n[gidx*SW +: SW];
  assign op = bus.req_op[gidx*2 +: 2];
  assign sra = $signed(src) >>> n;
  assign result = op == OP_SLL ? src << n : op == OP_SRL ? src >> n : op == OP_SRA ? sra : '0;
  always_comb state_d = flush ? EMPTY : advance ? FULL : bus.resp_ready ? EMPTY : state_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= EMPTY;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.resp_data <= '0;
      bus.resp_id <= '0;
      bus.resp_err <= 1'b0;
    end else if (advance) begin
      bus.resp_data <= result;
      bus.resp_id <= gidx;
      bus.resp_err <= op == OP_RSV;
    end
endmodule

// File: tb/tb_shift_arb.sv
// tb_shift_arb: scoreboard bench for shift_arb with directed vectors and hand-computed results
module tb_shift_arb;
  import shift_pkg::*;
  localparam int DW = 32;
  localparam int NREQ = 2;
  localparam int SW = 5;
  typedef struct packed {logic [31:0] d; logic id; logic err;} rsp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  always #5 clk = ~clk;
  shift_arb_if #(.DW(DW), .NREQ(NREQ)) bus();
  shift_arb #(.DW(DW), .NREQ(NREQ)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  rsp_t q[$];
  rsp_t e;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_d [2];
  logic exp_e [2];
  logic m_full = 0;
  logic m_ptr = 0;
  logic [31:0] held_d;
  logic held_id;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  task automatic set_req(input int i, input logic [31:0] src, input logic [4:0] n, input logic [1:0] op, input logic [31:0] x);
    bus.req_src[i*DW +: DW] = src;
    bus.req_n[i*SW +: SW] = n;
    bus.req_op[i*2 +: 2] = op;
    exp_d[i] = x;
    exp_e[i] = op == OP_RSV;
  endtask
  task automatic cycle(input logic [1:0] v, input logic rr, input logic fl);
    logic [1:0] g;
    logic id;
    bus.req_valid = v;
    bus.resp_ready = rr;
    flush = fl;
    @(negedge clk);
    g = 2'b00;
    if ((!m_full || rr) && !fl)
      g = v[m_ptr] ? 2'(2'b01 << m_ptr) : v[!m_ptr] ? 2'(2'b01 << !m_ptr) : 2'b00;
    check("resp_valid", 32'(bus.resp_valid), 32'(m_full));
    check("req_ready", 32'(bus.req_ready), 32'(g));
    if (fl && m_full) void'(q.pop_back());
    if (g != 2'b00) begin
      id = g[1];
      q.push_back('{exp_d[id], id, exp_e[id]});
      m_ptr = !id;
    end
    m_full = fl ? 1'b0 : (g != 2'b00) ? 1'b1 : rr ? 1'b0 : m_full;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got data %h id %0d, expected no response", bus.resp_data, bus.resp_id);
      end else begin
        e = q.pop_front();
        check("resp_data", bus.resp_data, e.d);
        check("resp_id", 32'(bus.resp_id), 32'(e.id));
        check("resp_err", 32'(bus.resp_err), 32'(e.err));
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = '0;
    bus.resp_ready = 0;
    set_req(0, 0, 0, OP_SLL, 0);
    set_req(1, 0, 0, OP_SLL, 0);
    #12;
    check("rst_valid", 32'(bus.resp_valid), 0);
    check("rst_data", bus.resp_data, 0);
    check("rst_id", 32'(bus.resp_id), 0);
    check("rst_err", 32'(bus.resp_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    set_req(0, 32'h0000_0001, 4, OP_SLL, 32'h0000_0010);
    cycle(2'b01, 1, 0);
    cycle(2'b00, 1, 0);
    set_req(0, 32'h8000_0000, 31, OP_SRA, 32'hFFFF_FFFF);
    cycle(2'b01, 1, 0);
    set_req(1, 32'h8000_0000, 31, OP_SRL, 32'h0000_0001);
    cycle(2'b10, 1, 0);
    set_req(0, 32'hA5A5_1234, 0, OP_SRA, 32'hA5A5_1234);
    cycle(2'b01, 1, 0);
    set_req(1, 32'hDEAD_BEEF, 0, OP_SLL, 32'hDEAD_BEEF);
    cycle(2'b10, 1, 0);
    set_req(0, 32'h1234_5678, 0, OP_SRL, 32'h1234_5678);
    cycle(2'b01, 1, 0);
    set_req(1, 32'h4000_0000, 4, OP_SRA, 32'h0400_0000);
    cycle(2'b10, 1, 0);
    set_req(0, 32'h0000_0003, 31, OP_SLL, 32'h8000_0000);
    cycle(2'b01, 1, 0);
    set_req(1, 32'hF000_0000, 28, OP_SRL, 32'h0000_000F);
    cycle(2'b10, 1, 0);
    cycle(2'b00, 1, 0);
    set_req(0, 32'h0000_00FF, 8, OP_SLL, 32'h0000_FF00);
    set_req(1, 32'hFF00_0000, 8, OP_SRA, 32'hFFFF_0000);
    repeat (4) cycle(2'b11, 1, 0);
    cycle(2'b00, 1, 0);
    cycle(2'b11, 0, 0);
    held_d = bus.resp_data;
    held_id = bus.resp_id;
    repeat (3) begin
      cycle(2'b11, 0, 0);
      check("stall_data", bus.resp_data, held_d);
      check("stall_id", 32'(bus.resp_id), 32'(held_id));
    end
    cycle(2'b11, 1, 0);
    cycle(2'b00, 1, 0);
    cycle(2'b00, 1, 0);
    set_req(1, 32'hFFFF_FFFF, 3, OP_RSV, 32'h0000_0000);
    set_req(0, 32'h0000_0F00, 4, OP_SRL, 32'h0000_00F0);
    cycle(2'b10, 1, 0);
    cycle(2'b11, 1, 0);
    cycle(2'b00, 1, 0);
    cycle(2'b01, 0, 0);
    cycle(2'b00, 0, 1);
    cycle(2'b00, 1, 0);
    cycle(2'b01, 1, 1);
    cycle(2'b00, 1, 0);
    cycle(2'b01, 0, 0);
    rst_n = 0;
    m_full = 0;
    m_ptr = 0;
    q.delete();
    @(negedge clk);
    check("rst2_valid", 32'(bus.resp_valid), 0);
    check("rst2_data", bus.resp_data, 0);
    check("rst2_err", 32'(bus.resp_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    cycle(2'b11, 1, 0);
    cycle(2'b00, 1, 0);
    cycle(2'b00, 1, 0);
    check("queue_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
